// File: rtl/snake_pkg.sv
// Shared timing constants, tile-map geometry and arbiter state encoding for
// the snake tile-map controller.
package snake_pkg;

   localparam int H_ACTIVE      = 640;
   localparam int H_TOTAL       = 800;
   localparam int V_ACTIVE      = 480;
   localparam int V_TOTAL       = 525;

   // 32-px tiles, 256-px segments (eight 4-bit tile codes per map word)
   localparam int TILE_SHIFT    = 5;
   localparam int SEG_SHIFT     = 8;
   localparam int WORDS_PER_ROW = 3;
   localparam int TILE_ROWS     = (V_ACTIVE + (1 << TILE_SHIFT) - 1) >> TILE_SHIFT;
   localparam int MAP_WORDS     = TILE_ROWS * WORDS_PER_ROW;
   localparam int SEG_W         = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VRD,
      ST_VCAP,
      ST_WR,
      ST_CLR
   } arb_state_t;

endpackage

// File: rtl/snake_fetch_sched.sv
// Beam-position decode: decides when to prefetch the next segment's map
// word, which word that is, and when the prefetched word goes live.
module snake_fetch_sched
   import snake_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int FETCH_LEAD = 16
) (
   input  logic              pix_en,
   input  logic [11:0]       x,
   input  logic [11:0]       y,
   output logic              trig_rd,
   output logic              trig_blank,
   output logic [ADDR_W-1:0] trig_addr,
   output logic              load
);

   logic             hit;
   logic             ld;
   logic             blank;
   logic [SEG_W-1:0] seg;
   logic [11:0]      ty;
   logic [11:0]      row;
   logic [11:0]      idx;

   // Fetch trigger: FETCH_LEAD px before each in-line segment boundary, and
   // near end of line for segment 0 of the following line (wrapping frame).
   always_comb begin
      hit = 1'b0;
      seg = '0;
      ty  = y;
      for (int s = 0; s < WORDS_PER_ROW - 1; s++) begin
         if (x == 12'(((s + 1) << SEG_SHIFT) - FETCH_LEAD)) begin
            hit = 1'b1;
            seg = SEG_W'(s + 1);
         end
      end
      if (x == 12'(H_TOTAL - FETCH_LEAD)) begin
         hit = 1'b1;
         seg = '0;
         ty  = (y == 12'(V_TOTAL - 1)) ? 12'd0 : y + 12'd1;
      end
   end

   // Load point: last pixel of each segment, plus last pixel of the line.
   always_comb begin
      ld = 1'b0;
      for (int s = 0; s < WORDS_PER_ROW - 1; s++) begin
         if (x == 12'(((s + 1) << SEG_SHIFT) - 1)) ld = 1'b1;
      end
      if (x == 12'(H_TOTAL - 1)) ld = 1'b1;
   end

   // Lines in vertical blanking have no map row; the shadow is just zeroed.
   assign blank      = (ty >= 12'(V_ACTIVE));
   assign row        = ty >> TILE_SHIFT;
   assign idx        = 12'(row * 12'(WORDS_PER_ROW)) + 12'(seg);

   assign trig_rd    = pix_en & hit & ~blank;
   assign trig_blank = pix_en & hit & blank;
   assign trig_addr  = ADDR_W'(idx);
   assign load       = pix_en & ld;

endmodule

// File: rtl/snake_tilemap_ctrl.sv
// Tile-map RAM owner: arbitrates the single-port RAM between the video
// prefetch (highest), the full-map clear sweep and game-logic writes, and
// presents the current segment's tile codes on sprite_addr.
module snake_tilemap_ctrl
   import snake_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int FETCH_LEAD = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_en,
   input  logic [11:0]       x,
   input  logic [11:0]       y,
   output logic [31:0]       sprite_addr,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data,
   output logic              wr_ack,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   arb_state_t        state, state_nxt;
   logic              vid_pend;
   logic [ADDR_W-1:0] tgt_q;
   logic [31:0]       shadow;
   logic [ADDR_W-1:0] clr_cnt;

   logic              trig_rd;
   logic              trig_blank;
   logic [ADDR_W-1:0] trig_addr;
   logic              load;
   logic              vid_go;
   logic              clr_last;
   logic              wr_in_map;

   snake_fetch_sched #(
      .ADDR_W     (ADDR_W),
      .FETCH_LEAD (FETCH_LEAD)
   ) u_sched (
      .pix_en     (pix_en),
      .x          (x),
      .y          (y),
      .trig_rd    (trig_rd),
      .trig_blank (trig_blank),
      .trig_addr  (trig_addr),
      .load       (load)
   );

   // A trigger in this very cycle counts as pending so video beats a write
   // request that arrives together with it.
   assign vid_go    = vid_pend | trig_rd;
   assign clr_last  = (clr_cnt == ADDR_W'(MAP_WORDS - 1));
   assign wr_in_map = (wr_addr < ADDR_W'(MAP_WORDS));

   // Arbiter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Arbiter next state and RAM port mux.
   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      wr_ack    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (vid_go)        state_nxt = ST_VRD;
            else if (clr_busy) state_nxt = ST_CLR;
            else if (wr_req)   state_nxt = ST_WR;
         end
         ST_VRD: begin
            mem_en    = 1'b1;
            mem_addr  = tgt_q;
            state_nxt = ST_VCAP;
         end
         ST_VCAP: begin
            state_nxt = ST_IDLE;
         end
         ST_WR: begin
            // out-of-map writes are acknowledged but never reach the RAM
            mem_en    = wr_in_map;
            mem_we    = wr_in_map;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            wr_ack    = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_CLR: begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = clr_cnt;
            // yield to a pending fetch after each write; sweep resumes later
            if (clr_last || vid_go) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Video fetch bookkeeping: pending flag, target, shadow capture, display load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid_pend    <= 1'b0;
         tgt_q       <= '0;
         shadow      <= '0;
         sprite_addr <= '0;
      end else begin
         if (state == ST_VRD)  vid_pend <= 1'b0;
         if (state == ST_VCAP) shadow   <= mem_rdata;
         // a newer trigger simply overrides any target still pending
         if (trig_rd) begin
            vid_pend <= 1'b1;
            tgt_q    <= trig_addr;
         end
         if (trig_blank) begin
            vid_pend <= 1'b0;
            shadow   <= '0;
         end
         if (load) sprite_addr <= shadow;
      end
   end

   // Clear sweep control: start on request when idle, advance per CLR write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_busy <= 1'b0;
         clr_cnt  <= '0;
      end else if (clr_req && !clr_busy) begin
         clr_busy <= 1'b1;
         clr_cnt  <= '0;
      end else if (state == ST_CLR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_last) clr_busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_snake_tilemap_ctrl.sv
// Directed self-checking bench for snake_tilemap_ctrl with a behavioural
// single-port RAM (1-cycle read latency) attached to the mem_* port.
module tb_snake_tilemap_ctrl;

   localparam int AW = 6;
   localparam logic [31:0] W0 = 32'h76543210;
   localparam logic [31:0] W1 = 32'hFEDCBA98;
   localparam logic [31:0] W2 = 32'h0BADF00D;
   localparam logic [31:0] W3 = 32'hCAFE0003;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pix_en = 1'b0;
   logic [11:0]   x = '0;
   logic [11:0]   y = '0;
   logic [31:0]   sprite_addr;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [31:0]   wr_data = '0;
   logic          wr_ack;
   logic          clr_req = 1'b0;
   logic          clr_busy;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;

   logic [31:0]   ram [0:63];
   int            rd_cnt = 0;
   logic [AW-1:0] last_rd = '0;

   int errors = 0;
   int checks = 0;
   int px = 0;
   int py = 0;

   snake_tilemap_ctrl #(.ADDR_W(AW), .FETCH_LEAD(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .x           (x),
      .y           (y),
      .sprite_addr (sprite_addr),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .clr_req     (clr_req),
      .clr_busy    (clr_busy),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   // behavioural RAM plus a read observer
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else begin
            mem_rdata <= ram[mem_addr];
            rd_cnt    <= rd_cnt + 1;
            last_rd   <= mem_addr;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present pixels px,py with pix_en for n cycles, advancing the beam
   task automatic run_pix(input int n);
      for (int i = 0; i < n; i++) begin
         x = 12'(px);
         y = 12'(py);
         pix_en = 1'b1;
         tick();
         px++;
         if (px == 800) begin
            px = 0;
            py = (py == 524) ? 0 : py + 1;
         end
      end
      pix_en = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, output logic got);
      got = 1'b0;
      wr_addr = a;
      wr_data = d;
      wr_req  = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (wr_ack) begin
            got = 1'b1;
            break;
         end
      end
      wr_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (sprite_addr !== 32'h0 || wr_ack !== 1'b0 || clr_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outs: sprite=%h ack=%b busy=%b want 0/0/0", sprite_addr, wr_ack, clr_busy);
      end
      checks++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mem: en=%b we=%b addr=%0d wdata=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata);
      end
      tick();
      tick();
      #3 rst_n = 1'b1;
      tick();
      checks++;
      if (mem_en !== 1'b0 || sprite_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_idle: en=%b sprite=%h want 0/0", mem_en, sprite_addr);
      end
   endtask

   task automatic test_write();
      logic got;
      logic [31:0] wd [0:3];
      wd[0] = W0; wd[1] = W1; wd[2] = W2; wd[3] = W3;
      for (int i = 0; i < 4; i++) begin
         do_write(AW'(i), wd[i], got);
         checks++;
         if (!got || ram[i] !== wd[i]) begin
            errors++;
            $display("FAIL write_word%0d: ack=%b ram=%h want ack=1 ram=%h", i, got, ram[i], wd[i]);
         end
      end
      ram[50] = 32'h5A5A5A5A;
      do_write(AW'(50), 32'h11111111, got);
      checks++;
      if (!got || ram[50] !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL write_oob: ack=%b ram50=%h want ack=1 ram50=5a5a5a5a", got, ram[50]);
      end
      checks++;
      if (wr_ack !== 1'b0) begin
         errors++;
         $display("FAIL write_ack_pulse: ack=%b want 0 after request dropped", wr_ack);
      end
   endtask

   task automatic test_line0();
      px = 780; py = 524;
      run_pix(20);
      checks++;
      if (sprite_addr !== W0 || last_rd !== AW'(0)) begin
         errors++;
         $display("FAIL line0_seg0: sprite=%h rd=%0d want %h rd=0", sprite_addr, last_rd, W0);
      end
      run_pix(100);
      checks++;
      if (sprite_addr !== W0) begin
         errors++;
         $display("FAIL line0_hold: sprite=%h want %h", sprite_addr, W0);
      end
      run_pix(156);
      checks++;
      if (sprite_addr !== W1) begin
         errors++;
         $display("FAIL line0_seg1: sprite=%h want %h", sprite_addr, W1);
      end
      run_pix(256);
      checks++;
      if (sprite_addr !== W2) begin
         errors++;
         $display("FAIL line0_seg2: sprite=%h want %h", sprite_addr, W2);
      end
   endtask

   task automatic test_row_cross();
      px = 780; py = 31;
      run_pix(19);
      checks++;
      if (sprite_addr !== W2 || last_rd !== AW'(3)) begin
         errors++;
         $display("FAIL row_cross_pre: sprite=%h rd=%0d want %h rd=3", sprite_addr, last_rd, W2);
      end
      run_pix(1);
      checks++;
      if (sprite_addr !== W3) begin
         errors++;
         $display("FAIL row_cross_load: sprite=%h want %h", sprite_addr, W3);
      end
   endtask

   task automatic test_blank();
      int rd0;
      rd0 = rd_cnt;
      px = 780; py = 479;
      run_pix(20);
      checks++;
      if (sprite_addr !== 32'h0 || rd_cnt !== rd0) begin
         errors++;
         $display("FAIL blank_479: sprite=%h reads=%0d want 0 reads=0", sprite_addr, rd_cnt - rd0);
      end
      px = 240; py = 500;
      run_pix(20);
      checks++;
      if (sprite_addr !== 32'h0 || rd_cnt !== rd0) begin
         errors++;
         $display("FAIL blank_500: sprite=%h reads=%0d want 0 reads=0", sprite_addr, rd_cnt - rd0);
      end
      px = 780; py = 524;
      run_pix(20);
      checks++;
      if (sprite_addr !== W0 || rd_cnt !== rd0 + 1) begin
         errors++;
         $display("FAIL blank_resume: sprite=%h reads=%0d want %h reads=1", sprite_addr, rd_cnt - rd0, W0);
      end
   endtask

   task automatic test_back_to_back();
      int ack_i;
      logic [AW-1:0] ack_addr;
      logic ack_we;
      ack_i = -1; ack_addr = '0; ack_we = 1'b0;
      px = 783; py = 31;
      run_pix(1);
      x = 12'd784; y = 12'd31; pix_en = 1'b1;
      wr_addr = AW'(5); wr_data = 32'h13572468; wr_req = 1'b1;
      tick();
      pix_en = 1'b0;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(3)) begin
         errors++;
         $display("FAIL b2b_video_first: en=%b we=%b addr=%0d want 1/0/3", mem_en, mem_we, mem_addr);
      end
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (wr_ack) begin
            ack_i = i; ack_addr = mem_addr; ack_we = mem_we;
            break;
         end
      end
      wr_req = 1'b0;
      checks++;
      if (ack_i < 2 || ack_i > 3 || ack_addr !== AW'(5) || ack_we !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ack: cycle=%0d addr=%0d we=%b want cycle 2..3 addr=5 we=1", ack_i, ack_addr, ack_we);
      end
      tick();
      checks++;
      if (wr_ack !== 1'b0 || ram[5] !== 32'h13572468) begin
         errors++;
         $display("FAIL b2b_single_ack: ack=%b ram5=%h want 0 13572468", wr_ack, ram[5]);
      end
      px = 785; py = 31;
      run_pix(15);
      checks++;
      if (sprite_addr !== W3) begin
         errors++;
         $display("FAIL b2b_shadow: sprite=%h want %h", sprite_addr, W3);
      end
   endtask

   task automatic test_clear();
      int busy_cnt, clr_wr, ack_c, rd0, bad;
      logic busy_at_ack;
      busy_cnt = 0; clr_wr = 0; ack_c = -1; bad = 0; busy_at_ack = 1'b1;
      for (int i = 0; i < 45; i++) ram[i] = 32'h1000 + i;
      rd0 = rd_cnt;
      for (int c = 0; c < 300; c++) begin
         clr_req = (c == 0 || c == 15);
         if (c == 10) begin
            x = 12'd240; y = 12'd0; pix_en = 1'b1;
         end else pix_en = 1'b0;
         if (c == 15) begin
            wr_addr = AW'(7); wr_data = 32'hAAAA5555; wr_req = 1'b1;
         end
         tick();
         if (clr_busy) busy_cnt++;
         if (mem_en && mem_we && !wr_ack) clr_wr++;
         if (wr_ack) begin
            ack_c = c; busy_at_ack = clr_busy; wr_req = 1'b0;
         end
         if (ack_c >= 0 && !clr_busy) break;
      end
      clr_req = 1'b0; pix_en = 1'b0; wr_req = 1'b0;
      checks++;
      if (clr_wr !== 45) begin
         errors++;
         $display("FAIL clr_writes: got %0d want 45", clr_wr);
      end
      checks++;
      if (busy_cnt < 45 + 2 || busy_cnt > 60) begin
         errors++;
         $display("FAIL clr_busy_len: got %0d cycles want 47..60", busy_cnt);
      end
      checks++;
      if (ack_c < 0 || busy_at_ack !== 1'b0) begin
         errors++;
         $display("FAIL clr_wr_stall: ack_cycle=%0d busy_at_ack=%b want ack after sweep", ack_c, busy_at_ack);
      end
      checks++;
      if (rd_cnt - rd0 !== 1 || last_rd !== AW'(1)) begin
         errors++;
         $display("FAIL clr_steal: reads=%0d addr=%0d want 1 read of addr 1", rd_cnt - rd0, last_rd);
      end
      for (int k = 0; k < 20; k++) tick();
      for (int i = 0; i < 45; i++) begin
         if (i == 7) begin
            if (ram[i] !== 32'hAAAA5555) bad++;
         end else if (ram[i] !== 32'h0) bad++;
      end
      checks++;
      if (bad !== 0 || ram[50] !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL clr_contents: bad_words=%0d ram50=%h want 0 5a5a5a5a", bad, ram[50]);
      end
      px = 780; py = 524;
      run_pix(20);
      checks++;
      if (sprite_addr !== 32'h0) begin
         errors++;
         $display("FAIL clr_video: sprite=%h want 0", sprite_addr);
      end
   endtask

   task automatic test_reset_mid();
      logic got;
      int rd0;
      do_write(AW'(0), W0, got);
      px = 780; py = 524;
      run_pix(20);
      checks++;
      if (!got || sprite_addr !== W0) begin
         errors++;
         $display("FAIL rst_mid_setup: ack=%b sprite=%h want 1 %h", got, sprite_addr, W0);
      end
      wr_addr = AW'(9); wr_data = 32'hDEADBEEF; wr_req = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (sprite_addr !== 32'h0 || wr_ack !== 1'b0 || mem_en !== 1'b0 || clr_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_outs: sprite=%h ack=%b en=%b busy=%b want all 0", sprite_addr, wr_ack, mem_en, clr_busy);
      end
      wr_req = 1'b0;
      #20 rst_n = 1'b1;
      tick();
      checks++;
      if (ram[9] !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_nowrite: ram9=%h want 0", ram[9]);
      end
      rd0 = rd_cnt;
      px = 700; py = 524;
      run_pix(84);
      checks++;
      if (rd_cnt !== rd0) begin
         errors++;
         $display("FAIL rst_mid_early: reads=%0d want 0 before x=784", rd_cnt - rd0);
      end
      run_pix(16);
      checks++;
      if (rd_cnt !== rd0 + 1 || sprite_addr !== W0) begin
         errors++;
         $display("FAIL rst_mid_fetch: reads=%0d sprite=%h want 1 %h", rd_cnt - rd0, sprite_addr, W0);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = '0;
      test_reset();
      test_write();
      test_line0();
      test_row_cross();
      test_blank();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
